// File: rtl/phy_tx_pkg.sv
// Shared defaults for the phy_tx transmit path: lane width, lane buffer depth,
// idle character and the lane selector type.
package phy_tx_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned FifoDepth = 4;
  localparam logic [7:0]  IdleChar  = 8'hBC;

  // Names the lane the interleaver serves next.
  typedef enum logic {
    LaneSel0 = 1'b0,
    LaneSel1 = 1'b1
  } lane_sel_e;

  // Occupancy counter width: one extra bit so "full" is distinguishable from "empty".
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO. Depth must be a power of two (>= 2) so the
// read/write pointers wrap for free. Reset is synchronous and active-low.
module lane_fifo
  import phy_tx_pkg::*;
#(
  parameter int unsigned Width = DataWidth,
  parameter int unsigned Depth = FifoDepth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = cnt_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);

  // Full/empty come from pre-edge occupancy, so a full FIFO never takes a push
  // in the same cycle it pops.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign rdata_o = mem_q[rd_ptr_q];

  // Occupancy: push and pop together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy state with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lane_mux.sv
// Two-lane byte interleaver feeding the PHY. Lanes are served strictly
// 0,1,0,1,...; if the lane due next is empty the output idles and the
// selector waits rather than skipping ahead.
// Build option: define LANE_MUX_IDLE_EN to drive IDLE_CHAR on data_out during
// idle cycles; otherwise data_out holds the last byte sent.
module lane_mux
  import phy_tx_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DataWidth,
  parameter int unsigned           FIFO_DEPTH = FifoDepth,
  parameter logic [DATA_WIDTH-1:0] IDLE_CHAR  = DATA_WIDTH'(IdleChar)
) (
  input  logic                  clk_2f,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic                  valid_in_0,
  output logic                  ready_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic                  valid_in_1,
  output logic                  ready_1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

`ifdef LANE_MUX_IDLE_EN
  localparam logic [DATA_WIDTH-1:0] ResetData = IDLE_CHAR;
`else
  localparam logic [DATA_WIDTH-1:0] ResetData = '0;
  // Idle character has no role in the hold-last-byte build.
  logic [DATA_WIDTH-1:0] unused_idle_char;
  assign unused_idle_char = IDLE_CHAR;
`endif

  lane_sel_e             sel_q;
  logic [DATA_WIDTH-1:0] rdata_0, rdata_1;
  logic                  full_0, full_1, empty_0, empty_1;
  logic                  push_0, push_1, pop_0, pop_1;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_out_q;

  // Holding ready low in reset keeps inputs offered during reset out of the FIFOs.
  assign ready_0 = reset_L & ~full_0;
  assign ready_1 = reset_L & ~full_1;
  assign push_0  = valid_in_0 & ready_0;
  assign push_1  = valid_in_1 & ready_1;

  // Only the selected lane may pop; the other lane waits even if it has data.
  assign pop_0 = reset_L & (sel_q == LaneSel0) & ~empty_0;
  assign pop_1 = reset_L & (sel_q == LaneSel1) & ~empty_1;

  lane_fifo #(
    .Width(DATA_WIDTH),
    .Depth(FIFO_DEPTH)
  ) u_fifo_0 (
    .clk_i  (clk_2f),
    .rst_ni (reset_L),
    .push_i (push_0),
    .wdata_i(data_in_0),
    .pop_i  (pop_0),
    .rdata_o(rdata_0),
    .full_o (full_0),
    .empty_o(empty_0)
  );

  lane_fifo #(
    .Width(DATA_WIDTH),
    .Depth(FIFO_DEPTH)
  ) u_fifo_1 (
    .clk_i  (clk_2f),
    .rst_ni (reset_L),
    .push_i (push_1),
    .wdata_i(data_in_1),
    .pop_i  (pop_1),
    .rdata_o(rdata_1),
    .full_o (full_1),
    .empty_o(empty_1)
  );

  // Arbiter and registered output: pop the selected lane and flip the selector,
  // or idle with the selector held.
  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      sel_q       <= LaneSel0;
      valid_out_q <= 1'b0;
      data_out_q  <= ResetData;
    end else if (pop_0 || pop_1) begin
      data_out_q  <= pop_0 ? rdata_0 : rdata_1;
      valid_out_q <= 1'b1;
      sel_q       <= (sel_q == LaneSel0) ? LaneSel1 : LaneSel0;
    end else begin
      valid_out_q <= 1'b0;
`ifdef LANE_MUX_IDLE_EN
      data_out_q  <= IDLE_CHAR;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_lane_mux.sv
// Self-checking bench for lane_mux. A queue-based model of the two lanes and
// the strict 0,1,0,1 service order predicts ready, valid_out and data_out.
module tb_lane_mux;

  localparam int unsigned Width = 8;
  localparam int unsigned Depth = 4;
`ifdef LANE_MUX_IDLE_EN
  localparam logic [7:0] RstDout = 8'hBC;
`else
  localparam logic [7:0] RstDout = 8'h00;
`endif

  logic             clk_2f = 1'b0;
  logic             reset_L = 1'b0;
  logic [Width-1:0] data_in_0 = '0, data_in_1 = '0;
  logic             valid_in_0 = 1'b0, valid_in_1 = 1'b0;
  logic             ready_0, ready_1;
  logic [Width-1:0] data_out;
  logic             valid_out;

  lane_mux #(
    .DATA_WIDTH(Width),
    .FIFO_DEPTH(Depth),
    .IDLE_CHAR (8'hBC)
  ) dut (
    .clk_2f    (clk_2f),
    .reset_L   (reset_L),
    .data_in_0 (data_in_0),
    .valid_in_0(valid_in_0),
    .ready_0   (ready_0),
    .data_in_1 (data_in_1),
    .valid_in_1(valid_in_1),
    .ready_1   (ready_1),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  always #5 clk_2f = ~clk_2f;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         m_sel;
  bit         m_vout;
  logic [7:0] m_dout;
  bit         exp_r0, exp_r1;
  int         n_acc;

  // Observations from the last step
  logic       obs_r0, obs_r1, obs_v;
  logic [7:0] obs_d;

  // One clock: drive inputs after the falling edge, sample ready before the
  // rising edge and outputs just after it, and advance the model.
  task automatic step(input bit rl, input bit v0, input logic [7:0] d0,
                      input bit v1, input logic [7:0] d1);
    bit acc0, acc1;
    @(negedge clk_2f);
    reset_L = rl; valid_in_0 = v0; data_in_0 = d0; valid_in_1 = v1; data_in_1 = d1;
    #1;
    obs_r0 = ready_0;
    obs_r1 = ready_1;
    exp_r0 = rl && (q0.size() < Depth);
    exp_r1 = rl && (q1.size() < Depth);
    acc0 = v0 && exp_r0;
    acc1 = v1 && exp_r1;
    if (!rl) begin
      q0.delete(); q1.delete();
      m_sel = 0; m_vout = 0; m_dout = RstDout;
    end else begin
      if (!m_sel && q0.size() > 0) begin
        m_dout = q0.pop_front(); m_vout = 1; m_sel = 1;
      end else if (m_sel && q1.size() > 0) begin
        m_dout = q1.pop_front(); m_vout = 1; m_sel = 0;
      end else begin
        m_vout = 0;
`ifdef LANE_MUX_IDLE_EN
        m_dout = 8'hBC;
`endif
      end
      if (acc0) begin q0.push_back(d0); n_acc++; end
      if (acc1) begin q1.push_back(d1); n_acc++; end
    end
    @(posedge clk_2f);
    #1;
    obs_v = valid_out;
    obs_d = data_out;
  endtask

  task automatic test_reset();
    step(0, 1, 8'h11, 1, 8'h22);
    checks++;
    if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got r0=%0b r1=%0b want 0 0", obs_r0, obs_r1);
    end
    checks++;
    if (obs_v !== 1'b0 || obs_d !== RstDout) begin
      errors++;
      $display("FAIL reset_out: got v=%0b d=%02h want v=0 d=%02h", obs_v, obs_d, RstDout);
    end
    step(0, 1, 8'h33, 1, 8'h44);
    step(1, 0, 8'h00, 0, 8'h00);
    checks++;
    if (obs_v !== 1'b0 || obs_d !== RstDout || obs_r0 !== 1'b1 || obs_r1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_nostore: got v=%0b d=%02h r0=%0b r1=%0b want v=0 d=%02h r0=1 r1=1",
               obs_v, obs_d, obs_r0, obs_r1, RstDout);
    end
  endtask

  task automatic test_interleave();
    logic [7:0] l0 [3] = '{8'h01, 8'h03, 8'h05};
    logic [7:0] l1 [3] = '{8'h02, 8'h04, 8'h06};
    bit         ev [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] ed [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
    step(0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i < 3) step(1, 1, l0[i], 1, l1[i]);
      else       step(1, 0, 8'h00, 0, 8'h00);
      checks++;
      if (obs_v !== ev[i] || (ev[i] && obs_d !== ed[i])) begin
        errors++;
        $display("FAIL interleave_seq cyc %0d: got v=%0b d=%02h want v=%0b d=%02h",
                 i, obs_v, obs_d, ev[i], ed[i]);
      end
      checks++;
      if (obs_v !== m_vout || obs_d !== m_dout || obs_r0 !== exp_r0 || obs_r1 !== exp_r1) begin
        errors++;
        $display("FAIL interleave_model cyc %0d: got v=%0b d=%02h r=%0b%0b want v=%0b d=%02h r=%0b%0b",
                 i, obs_v, obs_d, obs_r0, obs_r1, m_vout, m_dout, exp_r0, exp_r1);
      end
    end
  endtask

  task automatic test_starve();
    bit         ev [7] = '{0, 0, 0, 0, 0, 1, 1};
    logic [7:0] ed [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'hAA};
    step(0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      step(1, 0, 8'h00, 1, 8'hAA);
      else if (i == 4) step(1, 1, 8'h55, 0, 8'h00);
      else             step(1, 0, 8'h00, 0, 8'h00);
      checks++;
      if (obs_v !== ev[i] || (ev[i] && obs_d !== ed[i])) begin
        errors++;
        $display("FAIL starve_seq cyc %0d: got v=%0b d=%02h want v=%0b d=%02h",
                 i, obs_v, obs_d, ev[i], ed[i]);
      end
      checks++;
      if (obs_v !== m_vout || obs_d !== m_dout || obs_r0 !== exp_r0 || obs_r1 !== exp_r1) begin
        errors++;
        $display("FAIL starve_model cyc %0d: got v=%0b d=%02h r=%0b%0b want v=%0b d=%02h r=%0b%0b",
                 i, obs_v, obs_d, obs_r0, obs_r1, m_vout, m_dout, exp_r0, exp_r1);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int outs = 0;
    step(0, 0, 8'h00, 0, 8'h00);
    step(1, 1, 8'h10, 0, 8'h00);
    step(1, 0, 8'h00, 0, 8'h00);  // 0x10 leaves, selector now waits on lane 1
    if (obs_v === 1'b1) outs++;
    for (int i = 0; i < 16; i++) begin
      bit pend = (acc < 5);
      step(1, pend, 8'h20 + 8'(acc), (i == 8), 8'h99);
      if (pend && obs_r0 === 1'b1) acc++;
      if (obs_v === 1'b1) outs++;
      checks++;
      if (obs_v !== m_vout || obs_d !== m_dout || obs_r0 !== exp_r0 || obs_r1 !== exp_r1) begin
        errors++;
        $display("FAIL backpressure_model cyc %0d: got v=%0b d=%02h r=%0b%0b want v=%0b d=%02h r=%0b%0b",
                 i, obs_v, obs_d, obs_r0, obs_r1, m_vout, m_dout, exp_r0, exp_r1);
      end
      if (i == 7) begin
        checks++;
        if (acc != 4 || obs_r0 !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_full: got accepted=%0d ready_0=%0b want accepted=4 ready_0=0",
                   acc, obs_r0);
        end
      end
    end
    checks++;
    if (acc != 5 || outs != 3) begin
      errors++;
      $display("FAIL backpressure_drain: got accepted=%0d outputs=%0d want accepted=5 outputs=3",
               acc, outs);
    end
  endtask

  task automatic test_reset_midstream();
    step(0, 0, 8'h00, 0, 8'h00);
    step(1, 1, 8'hA1, 1, 8'hB1);
    step(1, 1, 8'hA2, 1, 8'hB2);
    step(1, 0, 8'h00, 0, 8'h00);
    checks++;
    if (obs_v !== 1'b1 || obs_d !== 8'hB1) begin
      errors++;
      $display("FAIL midreset_pre: got v=%0b d=%02h want v=1 d=b1", obs_v, obs_d);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 8'hEE, 1, 8'hEF);
      checks++;
      if (obs_v !== 1'b0 || obs_d !== RstDout || obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin
        errors++;
        $display("FAIL midreset_hold cyc %0d: got v=%0b d=%02h r=%0b%0b want v=0 d=%02h r=00",
                 i, obs_v, obs_d, obs_r0, obs_r1, RstDout);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'h00, 0, 8'h00);
      checks++;
      if (obs_v !== 1'b0) begin
        errors++;
        $display("FAIL midreset_discard cyc %0d: got v=%0b d=%02h want v=0", i, obs_v, obs_d);
      end
    end
    step(1, 1, 8'h66, 1, 8'h77);
    step(1, 0, 8'h00, 0, 8'h00);
    checks++;
    if (obs_v !== 1'b1 || obs_d !== 8'h66) begin
      errors++;
      $display("FAIL midreset_lane0_first: got v=%0b d=%02h want v=1 d=66", obs_v, obs_d);
    end
    step(1, 0, 8'h00, 0, 8'h00);
    checks++;
    if (obs_v !== 1'b1 || obs_d !== 8'h77) begin
      errors++;
      $display("FAIL midreset_lane1_next: got v=%0b d=%02h want v=1 d=77", obs_v, obs_d);
    end
  endtask

  task automatic test_idle_hold();
`ifdef LANE_MUX_IDLE_EN
    logic [7:0] idle_exp = 8'hBC;
`else
    logic [7:0] idle_exp = 8'h7E;
`endif
    step(0, 0, 8'h00, 0, 8'h00);
    step(1, 1, 8'h3C, 1, 8'h7E);
    step(1, 0, 8'h00, 0, 8'h00);
    step(1, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'h00, 0, 8'h00);
      checks++;
      if (obs_v !== 1'b0 || obs_d !== idle_exp) begin
        errors++;
        $display("FAIL idle_hold cyc %0d: got v=%0b d=%02h want v=0 d=%02h",
                 i, obs_v, obs_d, idle_exp);
      end
    end
  endtask

  task automatic test_random_wrap();
    int outs = 0;
    step(0, 0, 8'h00, 0, 8'h00);
    n_acc = 0;
    for (int i = 0; i < 320; i++) begin
      bit heavy = (i % 64) < 32;
      bit v0 = heavy ? 1'b1 : ($urandom_range(0, 3) != 0);
      bit v1 = heavy ? 1'b1 : ($urandom_range(0, 2) == 0);
      step(1, v0, 8'($urandom), v1, 8'($urandom));
      if (obs_v === 1'b1) outs++;
      checks++;
      if (obs_v !== m_vout || obs_d !== m_dout || obs_r0 !== exp_r0 || obs_r1 !== exp_r1) begin
        errors++;
        $display("FAIL random_model cyc %0d: got v=%0b d=%02h r=%0b%0b want v=%0b d=%02h r=%0b%0b",
                 i, obs_v, obs_d, obs_r0, obs_r1, m_vout, m_dout, exp_r0, exp_r1);
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 8'h00, 0, 8'h00);
      if (obs_v === 1'b1) outs++;
    end
    checks++;
    if (outs + q0.size() + q1.size() != n_acc) begin
      errors++;
      $display("FAIL random_conservation: got out=%0d left=%0d want accepted=%0d",
               outs, q0.size() + q1.size(), n_acc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_interleave();
    test_starve();
    test_backpressure();
    test_reset_midstream();
    test_idle_hold();
    test_random_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
